// File: rtl/bpu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bpu_pkg
// Description : Shared encodings, queue entry layout and the bimodal
//               next-state helper for the branch-predictor update queue.
// Revision    : 1.0 - initial release
// ============================================================================
package bpu_pkg;

  // Two-bit saturating-counter prediction states
  localparam logic [1:0] PRED_STRONG_NT = 2'b00;
  localparam logic [1:0] PRED_WEAK_NT   = 2'b01;
  localparam logic [1:0] PRED_WEAK_T    = 2'b10;
  localparam logic [1:0] PRED_STRONG_T  = 2'b11;

  // Per-entry metadata; the predictor-state address is stored alongside it
  // because its width is a module parameter.
  typedef struct packed {
    logic       was_pred;
    logic [1:0] ps_state;
    logic       direction;
  } uq_meta_t;

  localparam int META_W = $bits(uq_meta_t);

  // Saturating bimodal update: taken counts up, not-taken counts down
  function automatic logic [1:0] bimodal_next(input logic [1:0] state,
                                              input logic       taken);
    logic [1:0] nxt;
    nxt = state;
    if (taken) begin
      if (state != PRED_STRONG_T) nxt = state + 2'd1;
    end else begin
      if (state != PRED_STRONG_NT) nxt = state - 2'd1;
    end
    return nxt;
  endfunction

endpackage
`default_nettype wire

// File: rtl/bpu_uq_fifo.sv
`default_nettype none
// ============================================================================
// Module      : bpu_uq_fifo
// Description : Entry storage for the predictor update queue: wrapping
//               read/write pointers, occupancy counter, per-entry valid bits
//               and an in-place state rewrite port used for chaining.
// Revision    : 1.0 - initial release
// ============================================================================
module bpu_uq_fifo
  import bpu_pkg::*;
#(
  parameter int PS_SIZE = 8,
  parameter int UQ_LOG2 = 2
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              i_push,
  input  logic [META_W-1:0]                 i_push_meta,
  input  logic [PS_SIZE-1:0]                i_push_addr,
  input  logic                              i_pop,
  input  logic [(2**UQ_LOG2)-1:0]           i_upd_mask,
  input  logic [1:0]                        i_upd_state,
  output logic [UQ_LOG2:0]                  o_count,
  output logic [META_W-1:0]                 o_head_meta,
  output logic [PS_SIZE-1:0]                o_head_addr,
  output logic [UQ_LOG2-1:0]                o_rd_ptr,
  output logic [(2**UQ_LOG2)-1:0]           o_valid,
  output logic [(2**UQ_LOG2)*PS_SIZE-1:0]   o_addr_flat
);

  localparam int DEPTH = 2**UQ_LOG2;

  uq_meta_t             r_meta [DEPTH];
  logic [PS_SIZE-1:0]   r_addr [DEPTH];
  logic [DEPTH-1:0]     r_valid;
  logic [UQ_LOG2-1:0]   r_wr_ptr;
  logic [UQ_LOG2-1:0]   r_rd_ptr;
  logic [UQ_LOG2:0]     r_count;

  // Storage update: chaining rewrites first, then pop clears the head slot,
  // then push fills the tail slot (push never targets a valid slot).
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_meta[i] <= '0;
        r_addr[i] <= '0;
      end
      r_valid  <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (i_upd_mask[i]) begin
          r_meta[i].was_pred <= 1'b1;
          r_meta[i].ps_state <= i_upd_state;
        end
      end
      if (i_pop) begin
        r_valid[r_rd_ptr] <= 1'b0;
        r_meta[r_rd_ptr]  <= '0;
        r_addr[r_rd_ptr]  <= '0;
        r_rd_ptr          <= r_rd_ptr + 1'b1;
      end
      if (i_push) begin
        r_valid[r_wr_ptr] <= 1'b1;
        r_meta[r_wr_ptr]  <= uq_meta_t'(i_push_meta);
        r_addr[r_wr_ptr]  <= i_push_addr;
        r_wr_ptr          <= r_wr_ptr + 1'b1;
      end
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_count     = r_count;
  assign o_head_meta = r_meta[r_rd_ptr];
  assign o_head_addr = r_addr[r_rd_ptr];
  assign o_rd_ptr    = r_rd_ptr;
  assign o_valid     = r_valid;

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_addr_flat
      assign o_addr_flat[gi*PS_SIZE +: PS_SIZE] = r_addr[gi];
    end
  endgenerate

endmodule
`default_nettype wire

// File: rtl/bpu_update_queue.sv
`default_nettype none
// ============================================================================
// Module      : bpu_update_queue
// Description : Buffers resolved-branch predictor updates and issues them to
//               the predictor-state array when fetch is not using the write
//               port. On issue, younger queued entries for the same address
//               are rewritten with the freshly written state so that they
//               build on it instead of on a stale fetch-time state.
//               Optional macro BPU_UQ_BYPASS_EN: when defined, a resolution
//               arriving at an empty, unblocked queue is issued directly in
//               the same cycle without being enqueued.
// Revision    : 1.0 - initial release
// ============================================================================
module bpu_update_queue
  import bpu_pkg::*;
#(
  parameter int PS_SIZE = 8,
  parameter int UQ_LOG2 = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               res_valid,
  output logic               res_ready,
  input  logic               res_was_pred,
  input  logic [1:0]         res_ps_state,
  input  logic [PS_SIZE-1:0] res_ps_addr,
  input  logic               res_direction,
  input  logic               ps_wr_block,
  output logic               wrb_update_bpu,
  output logic               wrb_was_pred,
  output logic [1:0]         wrb_ps_state,
  output logic [PS_SIZE-1:0] wrb_ps_addr,
  output logic               wrb_direction,
  output logic [UQ_LOG2:0]   uq_count
);

  localparam int               DEPTH     = 2**UQ_LOG2;
  localparam logic [UQ_LOG2:0] DEPTH_CNT = (UQ_LOG2+1)'(DEPTH);

  logic [UQ_LOG2:0]           w_count;
  uq_meta_t                   w_head_meta;
  logic [META_W-1:0]          w_head_meta_bits;
  logic [PS_SIZE-1:0]         w_head_addr;
  logic [UQ_LOG2-1:0]         w_rd_ptr;
  logic [DEPTH-1:0]           w_valid;
  logic [DEPTH*PS_SIZE-1:0]   w_addr_flat;
  logic                       w_queued_issue;
  logic                       w_bypass;
  logic                       w_push;
  logic [1:0]                 w_new_state;
  logic [DEPTH-1:0]           w_upd_mask;
  uq_meta_t                   w_push_meta;

  assign w_head_meta = uq_meta_t'(w_head_meta_bits);

  // Ready depends only on occupancy so a blocked queue still fills up
  assign res_ready      = (w_count != DEPTH_CNT);
  assign w_queued_issue = (w_count != '0) && !ps_wr_block;

`ifdef BPU_UQ_BYPASS_EN
  assign w_bypass = (w_count == '0) && res_valid && !ps_wr_block;
`else
  assign w_bypass = 1'b0;
`endif

  assign w_push = res_valid && res_ready && !w_bypass;

  // State written for the head entry: trained counter if it was predicted,
  // otherwise a weak state leaning toward the actual outcome
  assign w_new_state = w_head_meta.was_pred
                     ? bimodal_next(w_head_meta.ps_state, w_head_meta.direction)
                     : {w_head_meta.direction, !w_head_meta.direction};

  // Chain the written state into every other queued entry of the same address
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_chain
      assign w_upd_mask[gi] = w_queued_issue && w_valid[gi]
                           && (w_addr_flat[gi*PS_SIZE +: PS_SIZE] == w_head_addr)
                           && (UQ_LOG2'(gi) != w_rd_ptr);
    end
  endgenerate

  // Incoming entry also picks up the chained state when it hits the issuing address
  always_comb begin
    w_push_meta.was_pred  = res_was_pred;
    w_push_meta.ps_state  = res_ps_state;
    w_push_meta.direction = res_direction;
    if (w_queued_issue && (res_ps_addr == w_head_addr)) begin
      w_push_meta.was_pred = 1'b1;
      w_push_meta.ps_state = w_new_state;
    end
  end

  bpu_uq_fifo #(
    .PS_SIZE (PS_SIZE),
    .UQ_LOG2 (UQ_LOG2)
  ) u_fifo (
    .clk         (clk),
    .reset       (reset),
    .i_push      (w_push),
    .i_push_meta (w_push_meta),
    .i_push_addr (res_ps_addr),
    .i_pop       (w_queued_issue),
    .i_upd_mask  (w_upd_mask),
    .i_upd_state (w_new_state),
    .o_count     (w_count),
    .o_head_meta (w_head_meta_bits),
    .o_head_addr (w_head_addr),
    .o_rd_ptr    (w_rd_ptr),
    .o_valid     (w_valid),
    .o_addr_flat (w_addr_flat)
  );

  // Write-port payload: head entry, or the live input when bypassing
  always_comb begin
    wrb_update_bpu = w_queued_issue;
    wrb_was_pred   = w_head_meta.was_pred;
    wrb_ps_state   = w_head_meta.ps_state;
    wrb_ps_addr    = w_head_addr;
    wrb_direction  = w_head_meta.direction;
    if (w_bypass) begin
      wrb_update_bpu = 1'b1;
      wrb_was_pred   = res_was_pred;
      wrb_ps_state   = res_ps_state;
      wrb_ps_addr    = res_ps_addr;
      wrb_direction  = res_direction;
    end
  end

  assign uq_count = w_count;

endmodule
`default_nettype wire

// File: tb/tb_bpu_update_queue.sv
`default_nettype none
// ============================================================================
// Module      : tb_bpu_update_queue
// Description : Directed self-checking bench for bpu_update_queue (default
//               build, bypass disabled).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bpu_update_queue;

  localparam int PS_SIZE = 8;
  localparam int UQ_LOG2 = 2;

  logic               clk;
  logic               reset;
  logic               res_valid;
  logic               res_ready;
  logic               res_was_pred;
  logic [1:0]         res_ps_state;
  logic [PS_SIZE-1:0] res_ps_addr;
  logic               res_direction;
  logic               ps_wr_block;
  logic               wrb_update_bpu;
  logic               wrb_was_pred;
  logic [1:0]         wrb_ps_state;
  logic [PS_SIZE-1:0] wrb_ps_addr;
  logic               wrb_direction;
  logic [UQ_LOG2:0]   uq_count;

  int n_tests;
  int n_fail;

  bpu_update_queue #(
    .PS_SIZE (PS_SIZE),
    .UQ_LOG2 (UQ_LOG2)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .res_valid      (res_valid),
    .res_ready      (res_ready),
    .res_was_pred   (res_was_pred),
    .res_ps_state   (res_ps_state),
    .res_ps_addr    (res_ps_addr),
    .res_direction  (res_direction),
    .ps_wr_block    (ps_wr_block),
    .wrb_update_bpu (wrb_update_bpu),
    .wrb_was_pred   (wrb_was_pred),
    .wrb_ps_state   (wrb_ps_state),
    .wrb_ps_addr    (wrb_ps_addr),
    .wrb_direction  (wrb_direction),
    .uq_count       (uq_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Apply a resolution offer and let combinational outputs settle
  task automatic drive(input logic v, input logic wp, input logic [1:0] st,
                       input logic [7:0] a, input logic d);
    res_valid     = v;
    res_was_pred  = wp;
    res_ps_state  = st;
    res_ps_addr   = a;
    res_direction = d;
    #1;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    reset         = 1'b0;
    ps_wr_block   = 1'b0;
    res_valid     = 1'b0;
    res_was_pred  = 1'b0;
    res_ps_state  = 2'b00;
    res_ps_addr   = '0;
    res_direction = 1'b0;

    // ---------------- reset state ----------------
    #2;
    chk("rst_count", uq_count, 0);
    chk("rst_update", wrb_update_bpu, 0);
    step();
    step();
    reset = 1'b1;
    #1;
    chk("rel_count", uq_count, 0);
    chk("rel_update", wrb_update_bpu, 0);
    chk("rel_ready", res_ready, 1);
    chk("rel_addr", wrb_ps_addr, 0);
    chk("rel_state", wrb_ps_state, 0);

    // ---------------- single accept, one-cycle latency ----------------
    drive(1, 1, 2'b01, 8'h10, 1);
    chk("single_ready", res_ready, 1);
    chk("single_no_bypass", wrb_update_bpu, 0);
    step();
    drive(0, 0, 2'b00, 8'h00, 0);
    chk("single_count1", uq_count, 1);
    chk("single_update", wrb_update_bpu, 1);
    chk("single_addr", wrb_ps_addr, 8'h10);
    chk("single_state", wrb_ps_state, 2'b01);
    chk("single_wp", wrb_was_pred, 1);
    chk("single_dir", wrb_direction, 1);
    step();
    chk("single_count0", uq_count, 0);
    chk("single_update0", wrb_update_bpu, 0);

    // ---------------- fill while blocked, then drain in order ----------------
    ps_wr_block = 1'b1;
    for (int k = 0; k < 5; k++) begin
      drive(1, 0, k[1:0], 8'h30 + k[7:0], k[0]);
      chk("fill_ready", res_ready, (k < 4) ? 1 : 0);
      chk("fill_blocked", wrb_update_bpu, 0);
      step();
    end
    drive(0, 0, 2'b00, 8'h00, 0);
    chk("fill_count", uq_count, 4);
    chk("fill_full_ready", res_ready, 0);
    ps_wr_block = 1'b0;
    #1;
    for (int k = 0; k < 4; k++) begin
      chk("drain_update", wrb_update_bpu, 1);
      chk("drain_addr", wrb_ps_addr, 8'h30 + k);
      chk("drain_state", wrb_ps_state, k % 4);
      chk("drain_dir", wrb_direction, k % 2);
      chk("drain_count", uq_count, 4 - k);
      step();
    end
    chk("drain_empty", uq_count, 0);
    chk("drain_idle", wrb_update_bpu, 0);

    // ---------------- chaining: predicted taken on same address ----------------
    ps_wr_block = 1'b1;
    drive(1, 1, 2'b10, 8'h22, 1);
    step();
    drive(1, 1, 2'b10, 8'h22, 1);
    step();
    drive(0, 0, 2'b00, 8'h00, 0);
    chk("chain22_count", uq_count, 2);
    ps_wr_block = 1'b0;
    #1;
    chk("chain22_first_upd", wrb_update_bpu, 1);
    chk("chain22_first_state", wrb_ps_state, 2'b10);
    step();
    chk("chain22_count1", uq_count, 1);
    chk("chain22_second_addr", wrb_ps_addr, 8'h22);
    chk("chain22_second_state", wrb_ps_state, 2'b11);
    chk("chain22_second_wp", wrb_was_pred, 1);
    step();
    chk("chain22_empty", uq_count, 0);

    // ---------------- chaining: unpredicted not-taken ----------------
    ps_wr_block = 1'b1;
    drive(1, 0, 2'b00, 8'h05, 0);
    step();
    drive(1, 0, 2'b11, 8'h05, 1);
    step();
    drive(0, 0, 2'b00, 8'h00, 0);
    ps_wr_block = 1'b0;
    #1;
    chk("chain05_first_wp", wrb_was_pred, 0);
    chk("chain05_first_state", wrb_ps_state, 2'b00);
    step();
    chk("chain05_second_wp", wrb_was_pred, 1);
    chk("chain05_second_state", wrb_ps_state, 2'b01);
    chk("chain05_second_dir", wrb_direction, 1);
    step();
    chk("chain05_empty", uq_count, 0);

    // ---------------- chaining into an entry enqueued on the issue cycle ----------------
    drive(1, 1, 2'b01, 8'h40, 1);
    step();
    drive(1, 0, 2'b00, 8'h40, 0);
    chk("samecyc_first_upd", wrb_update_bpu, 1);
    chk("samecyc_first_state", wrb_ps_state, 2'b01);
    step();
    drive(0, 0, 2'b00, 8'h00, 0);
    chk("samecyc_count", uq_count, 1);
    chk("samecyc_wp", wrb_was_pred, 1);
    chk("samecyc_state", wrb_ps_state, 2'b10);
    chk("samecyc_dir", wrb_direction, 0);
    step();
    chk("samecyc_empty", uq_count, 0);

    // ---------------- steady count of 2 with pointer wrap ----------------
    ps_wr_block = 1'b1;
    drive(1, 1, 2'b00, 8'h50, 1);
    step();
    drive(1, 1, 2'b01, 8'h51, 1);
    step();
    ps_wr_block = 1'b0;
    for (int k = 0; k < 10; k++) begin
      drive(1, 1, k[1:0], 8'h52 + k[7:0], 1);
      chk("wrap_count", uq_count, 2);
      chk("wrap_update", wrb_update_bpu, 1);
      chk("wrap_addr", wrb_ps_addr, 8'h50 + k);
      step();
    end
    drive(0, 0, 2'b00, 8'h00, 0);
    chk("wrap_tail0_addr", wrb_ps_addr, 8'h5A);
    chk("wrap_tail0_count", uq_count, 2);
    step();
    chk("wrap_tail1_addr", wrb_ps_addr, 8'h5B);
    chk("wrap_tail1_count", uq_count, 1);
    step();
    chk("wrap_empty", uq_count, 0);

    // ---------------- reset with entries pending ----------------
    ps_wr_block = 1'b1;
    for (int k = 0; k < 3; k++) begin
      drive(1, 1, 2'b11, 8'h60 + k[7:0], 1);
      step();
    end
    drive(0, 0, 2'b00, 8'h00, 0);
    chk("midrst_pre_count", uq_count, 3);
    ps_wr_block = 1'b0;
    reset = 1'b0;
    #1;
    chk("midrst_count", uq_count, 0);
    chk("midrst_update", wrb_update_bpu, 0);
    chk("midrst_addr", wrb_ps_addr, 0);
    step();
    step();
    chk("midrst_hold_update", wrb_update_bpu, 0);
    reset = 1'b1;
    #1;
    chk("midrst_rel_count", uq_count, 0);
    chk("midrst_rel_update", wrb_update_bpu, 0);
    chk("midrst_rel_ready", res_ready, 1);
    step();
    chk("midrst_stale_update", wrb_update_bpu, 0);
    chk("midrst_stale_count", uq_count, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Safety net so the run always terminates
  initial begin
    #100000;
    $display("FAIL timeout: observed no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire

// File: doc/bpu_update_queue.md
BPU_UPDATE_QUEUE -- requirements
Module: bpu_update_queue

Interface
REQ-001 The module SHALL take parameter PS_SIZE, default 8, the log2 of the number of predictor-state entries and the address width.
REQ-002 The module SHALL take parameter UQ_LOG2, default 2, the log2 of the queue depth (depth 4).
REQ-003 The module SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The module SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-005 The module SHALL have port res_valid, input, 1 bit: a branch resolution is offered.
REQ-006 The module SHALL have port res_ready, output, 1 bit: the queue accepts the offered resolution this cycle.
REQ-007 The module SHALL have port res_was_pred, input, 1 bit: res_ps_state is valid.
REQ-008 The module SHALL have port res_ps_state, input, 2 bits: the prediction state used at fetch.
REQ-009 The module SHALL have port res_ps_addr, input, PS_SIZE bits: the predictor-state index.
REQ-010 The module SHALL have port res_direction, input, 1 bit: the actual branch outcome.
REQ-011 The module SHALL have port ps_wr_block, input, 1 bit: inhibits issue this cycle (fetch has priority).
REQ-012 The module SHALL have port wrb_update_bpu, output, 1 bit: a predictor-state write is issued.
REQ-013 The module SHALL have port wrb_was_pred, output, 1 bit: the issued entry's was_pred bit.
REQ-014 The module SHALL have port wrb_ps_state, output, 2 bits: the issued entry's prediction state.
REQ-015 The module SHALL have port wrb_ps_addr, output, PS_SIZE bits: the issued entry's address.
REQ-016 The module SHALL have port wrb_direction, output, 1 bit: the issued entry's outcome.
REQ-017 The module SHALL have port uq_count, output, UQ_LOG2+1 bits: the current occupancy.

Function
REQ-018 The module SHALL implement a FIFO of 2**UQ_LOG2 entries, each holding {was_pred, ps_state, ps_addr, direction}, using wrapping read/write pointers of UQ_LOG2 bits and an occupancy counter of UQ_LOG2+1 bits.
REQ-019 The module SHALL drive res_ready = (uq_count != depth), independent of ps_wr_block.
REQ-020 The module SHALL enqueue an entry on a cycle where res_valid and res_ready are both 1; with res_ready 0, the input is ignored and the offering source holds it.
REQ-021 The module SHALL drive the wrb_* payload combinationally from the head entry and set wrb_update_bpu = (uq_count != 0) && !ps_wr_block; issue dequeues the head the same cycle.
REQ-022 On a cycle with simultaneous enqueue and issue, uq_count SHALL be unchanged, and both pointers SHALL advance.
REQ-023 The module SHALL compute the written state W of an issued entry as: if was_pred, the bimodal next state (not-taken decrements, taken increments, saturating at 0 and 3); otherwise {direction, !direction}.
REQ-024 On issue of address A, every younger valid queued entry with ps_addr == A SHALL be rewritten to was_pred=1 and ps_state=W, including an entry enqueued in the same cycle with res_ps_addr == A.
REQ-025 If ps_wr_block is held, the queue SHALL retain all entries, issue nothing, and keep asserting res_ready until full.
REQ-026 Pointers SHALL wrap from depth-1 to 0 with no lost or duplicated entries.

Reset
REQ-027 When reset is low, the module SHALL clear the pointers, uq_count and all entry valid/payload fields to 0 immediately; wrb_update_bpu=0, wrb_*=0 and res_ready=1 on release.
REQ-028 A reset asserted mid-operation SHALL discard pending updates; no partial write SHALL issue.

Configuration
REQ-029 Macro BPU_UQ_BYPASS_EN SHALL control the empty-queue bypass path.
REQ-030 With BPU_UQ_BYPASS_EN defined and uq_count==0, res_valid=1 and ps_wr_block=0, the module SHALL present the input directly on wrb_* with wrb_update_bpu=1 in the same cycle and SHALL NOT enqueue it.
REQ-031 Without BPU_UQ_BYPASS_EN, every resolution SHALL be enqueued first, giving a minimum latency of one cycle from acceptance to issue.

Structure
REQ-032 The package bpu_pkg SHALL hold the PRED_STRONG_NT/WEAK_NT/WEAK_T/STRONG_T encodings (00/01/10/11), the queue entry struct typedef, and the bimodal next-state function.
REQ-033 One sub-module, bpu_uq_fifo (entry storage, pointers, count), SHALL be used; chaining and issue logic SHALL stay in the top module.

Verification
REQ-034 The bench SHALL cover: single accept {was_pred=1, state=01, addr=0x10, dir=1}, no bypass -> next cycle wrb_update_bpu=1, addr=0x10, state=01, count 1->0.
REQ-035 The bench SHALL cover: five back-to-back valid inputs with ps_wr_block=1 -> first four accepted, res_ready=0 on the fifth, uq_count=4; release block -> four issues in order.
REQ-036 The bench SHALL cover: queued addr 0x22 {pred, 10, dir=1} followed by addr 0x22 {pred, 10, dir=1}, issue first -> second entry's state becomes 11 and issues with wrb_ps_state=11.
REQ-037 The bench SHALL cover: was_pred=0, dir=0 at addr 0x05, with a younger 0x05 entry -> the younger entry's state becomes 01 with was_pred=1.
REQ-038 The bench SHALL cover: 10 enqueue/issue cycles at a steady count of 2 -> pointers wrap, the output order matches the input order, and the count stays 2.
REQ-039 The bench SHALL cover: reset low with 3 entries queued -> uq_count=0, wrb_update_bpu=0 during reset and after release, and no stale issue.
